// File: rtl/wb_slot_router_pkg.sv
// wb_slot_router_pkg: shared constants for the slot router.
//   - FSM state type and encodings
//   - CSR word offsets inside the CSR window
//   - forced-ack data pattern and ID magic
package wb_slot_router_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_FWD  = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    localparam logic [7:0] CSR_IO_OWNER = 8'h00;
    localparam logic [7:0] CSR_STATUS   = 8'h04;
    localparam logic [7:0] CSR_ID       = 8'h08;

    localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;
    localparam logic [15:0] ID_MAGIC  = 16'h5752;

endpackage

// File: rtl/wb_slot_io_mux.sv
// wb_slot_io_mux: GPIO ownership mux.
//   owner          - slot index that drives the pads
//   slot_io_out_i  - per-slot pad outputs, slot s in [s*IO_PADS +: IO_PADS]
//   slot_io_oeb_i  - per-slot pad output-enables (active low)
//   io_out/io_oeb  - pad outputs; an owner outside the slot range parks
//                    every pad as an input
module wb_slot_io_mux #(
    parameter int N_SLOTS = 4,
    parameter int IO_PADS = 38
) (
    input  logic [3:0]                 owner,
    input  logic [N_SLOTS*IO_PADS-1:0] slot_io_out_i,
    input  logic [N_SLOTS*IO_PADS-1:0] slot_io_oeb_i,
    output logic [IO_PADS-1:0]         io_out,
    output logic [IO_PADS-1:0]         io_oeb
);

    logic [N_SLOTS-1:0][IO_PADS-1:0] out_v;
    logic [N_SLOTS-1:0][IO_PADS-1:0] oeb_v;

    assign out_v = slot_io_out_i;
    assign oeb_v = slot_io_oeb_i;

    always_comb begin
        io_out = '0;
        io_oeb = '1;
        for (int s = 0; s < N_SLOTS; s++) begin
            if (owner == 4'(s)) begin
                io_out = out_v[s];
                io_oeb = oeb_v[s];
            end
        end
    end

endmodule

// File: rtl/wb_slot_router.sv
// wb_slot_router: management Wishbone slave fanned out to N_SLOTS user cores.
//   wb_clk_i/wb_rst_ni        - clock, async active-low reset
//   wbs_*                     - management Wishbone slave (registered ack/data)
//   slot_cyc_o/slot_stb_o     - one-hot per-slot cycle/strobe
//   slot_we/sel/adr/dat_o     - shared registered request fields
//   slot_dat_i/slot_ack_i     - per-slot read data and ack
//   slot_io_*_i, io_out/oeb   - GPIO pads driven by the IO_OWNER slot
// Address bits [SLOT_AW +: 4] pick the slot; index N_SLOTS is the CSR window,
// anything above is unmapped (reads 0, writes dropped, still acked).
module wb_slot_router
    import wb_slot_router_pkg::*;
#(
    parameter int N_SLOTS = 4,
    parameter int SLOT_AW = 8,
    parameter int TIMEOUT = 255,
    parameter int IO_PADS = 38
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_ni,
    input  logic                       wbs_cyc_i,
    input  logic                       wbs_stb_i,
    input  logic                       wbs_we_i,
    input  logic [3:0]                 wbs_sel_i,
    input  logic [31:0]                wbs_adr_i,
    input  logic [31:0]                wbs_dat_i,
    output logic                       wbs_ack_o,
    output logic [31:0]                wbs_dat_o,
    output logic [N_SLOTS-1:0]         slot_cyc_o,
    output logic [N_SLOTS-1:0]         slot_stb_o,
    output logic                       slot_we_o,
    output logic [3:0]                 slot_sel_o,
    output logic [SLOT_AW-1:0]         slot_adr_o,
    output logic [31:0]                slot_dat_o,
    input  logic [N_SLOTS*32-1:0]      slot_dat_i,
    input  logic [N_SLOTS-1:0]         slot_ack_i,
    input  logic [N_SLOTS*IO_PADS-1:0] slot_io_out_i,
    input  logic [N_SLOTS*IO_PADS-1:0] slot_io_oeb_i,
    output logic [IO_PADS-1:0]         io_out,
    output logic [IO_PADS-1:0]         io_oeb
);

    state_t                   state;
    logic [15:0]              cnt;
    logic [3:0]               cur_idx;
    logic [3:0]               io_owner;
    logic                     st_to;
    logic [3:0]               st_slot;

    logic [3:0]               idx;
    logic [SLOT_AW-1:0]       off;
    logic                     acc;
    logic                     is_slot;
    logic                     is_csr;
    logic [31:0]              csr_rdat;
    logic                     cur_ack;
    logic [31:0]              cur_rdat;
    logic [N_SLOTS-1:0][31:0] sdat;
    logic                     unused_adr;

    // The SoC already decoded the user window; upper bits carry no meaning here.
    assign unused_adr = ^wbs_adr_i[31:SLOT_AW+4];

    assign sdat    = slot_dat_i;
    assign idx     = wbs_adr_i[SLOT_AW +: 4];
    assign off     = {wbs_adr_i[SLOT_AW-1:2], 2'b00};
    assign acc     = (state == ST_IDLE) && wbs_cyc_i && wbs_stb_i;
    assign is_slot = idx < 4'(N_SLOTS);
    assign is_csr  = idx == 4'(N_SLOTS);

    always_comb begin
        csr_rdat = '0;
        if (is_csr) begin
            case (off)
                SLOT_AW'(CSR_IO_OWNER): csr_rdat = {28'd0, io_owner};
                SLOT_AW'(CSR_STATUS):   csr_rdat = {20'd0, st_slot, 7'd0, st_to};
                SLOT_AW'(CSR_ID):       csr_rdat = {ID_MAGIC, 8'(N_SLOTS), 8'(TIMEOUT >> 8)};
                default:                csr_rdat = '0;
            endcase
        end
    end

    // Only the addressed slot's ack/data matter; other slots' acks are ignored.
    always_comb begin
        cur_ack  = 1'b0;
        cur_rdat = '0;
        for (int s = 0; s < N_SLOTS; s++) begin
            if (cur_idx == 4'(s)) begin
                cur_ack  = slot_ack_i[s];
                cur_rdat = sdat[s];
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            cur_idx    <= '0;
            io_owner   <= '0;
            st_to      <= 1'b0;
            st_slot    <= '0;
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= '0;
            slot_cyc_o <= '0;
            slot_stb_o <= '0;
            slot_we_o  <= 1'b0;
            slot_sel_o <= '0;
            slot_adr_o <= '0;
            slot_dat_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (acc) begin
                        cur_idx <= idx;
                        cnt     <= '0;
                        if (is_slot) begin
                            state      <= ST_FWD;
                            slot_cyc_o <= N_SLOTS'(1) << idx;
                            slot_stb_o <= N_SLOTS'(1) << idx;
                            slot_we_o  <= wbs_we_i;
                            slot_sel_o <= wbs_sel_i;
                            slot_adr_o <= wbs_adr_i[SLOT_AW-1:0];
                            slot_dat_o <= wbs_dat_i;
                        end else begin
                            // CSR and unmapped accesses complete without a slot phase.
                            state     <= ST_RESP;
                            wbs_ack_o <= 1'b1;
                            wbs_dat_o <= csr_rdat;
                            if (is_csr && wbs_we_i && wbs_sel_i[0]) begin
                                if (off == SLOT_AW'(CSR_IO_OWNER))
                                    io_owner <= wbs_dat_i[3:0];
                                if (off == SLOT_AW'(CSR_STATUS) && wbs_dat_i[0])
                                    st_to <= 1'b0;
                            end
                        end
                    end
                end
                ST_FWD: begin
                    cnt <= cnt + 16'd1;
                    if (!wbs_cyc_i) begin
                        // Master abort: no ack for a cycle the master gave up on.
                        state      <= ST_IDLE;
                        slot_cyc_o <= '0;
                        slot_stb_o <= '0;
                    end else if (cur_ack) begin
                        // Checked before the timeout so a last-cycle ack still counts.
                        state      <= ST_RESP;
                        wbs_ack_o  <= 1'b1;
                        wbs_dat_o  <= cur_rdat;
                        slot_cyc_o <= '0;
                        slot_stb_o <= '0;
                    end else if (cnt == 16'(TIMEOUT)) begin
                        state      <= ST_RESP;
                        wbs_ack_o  <= 1'b1;
                        wbs_dat_o  <= DEAD_BEEF;
                        st_to      <= 1'b1;
                        st_slot    <= cur_idx;
                        slot_cyc_o <= '0;
                        slot_stb_o <= '0;
                    end
                end
                ST_RESP: begin
                    // A strobe still held here belongs to the finished access.
                    wbs_ack_o <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    wb_slot_io_mux #(
        .N_SLOTS (N_SLOTS),
        .IO_PADS (IO_PADS)
    ) u_io_mux (
        .owner         (io_owner),
        .slot_io_out_i (slot_io_out_i),
        .slot_io_oeb_i (slot_io_oeb_i),
        .io_out        (io_out),
        .io_oeb        (io_oeb)
    );

endmodule
